// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable serial bit-pattern detector.
// The pattern can be up to PAT_W bits long. Overlap and non-overlap modes are
// selectable. Input bits are qualified by x_valid. A saturating match counter
// is provided.
// Optional build macro: SEQDET_MEALY_EN makes z a combinational (Mealy)
// output that fires in the same cycle as the completing bit. When the macro
// is undefined, z is a registered pulse one cycle later.
module seq_detector_param #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             x,
  input  logic             x_valid,
  input  logic             clr_cnt,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err,
  output logic             busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Compare the low len bits of the history against the pattern.
  // Bits at and above len are ignored.
  function automatic logic pattern_hit(input logic [PAT_W-1:0] hist,
                                       input logic [PAT_W-1:0] pat,
                                       input logic [LEN_W-1:0] len);
    logic [PAT_W-1:0] diff;
    logic             hit;
    diff = hist ^ pat;
    hit  = 1'b1;
    for (int i = 0; i < PAT_W; i++) begin
      hit = hit & ~(diff[i] & (i < int'(len)));
    end
    return hit;
  endfunction

  state_t           state_r;
  logic [PAT_W-1:0] history_r;
  logic [LEN_W-1:0] fill_r;
  logic [PAT_W-1:0] pattern_r;
  logic [LEN_W-1:0] len_r;
  logic             overlap_r;
  logic             cfg_err_r;
  logic             busy_r;
  logic [CNT_W-1:0] cnt_r;

  logic [PAT_W-1:0] nh_s;
  logic [LEN_W:0]   fill_inc_s;
  logic             len_ok_s;
  logic             match_s;

  // Next history, the legality check on the incoming length, and the match
  // decision for the bit presented this cycle. cfg_load discards a
  // coincident bit.
  always_comb begin
    nh_s       = {history_r[PAT_W-2:0], x};
    fill_inc_s = {1'b0, fill_r} + {{LEN_W{1'b0}}, 1'b1};
    len_ok_s   = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= LEN_W'(PAT_W));
    match_s    = 1'b0;
    if ((state_r == ST_RUN) && x_valid && !cfg_load) begin
      match_s = (fill_inc_s >= {1'b0, len_r}) && pattern_hit(nh_s, pattern_r, len_r);
    end else begin
      match_s = 1'b0;
    end
  end

  // Control FSM: configuration latch, history and fill tracking, and the
  // registered busy/cfg_err outputs.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r   <= ST_IDLE;
      history_r <= {PAT_W{1'b0}};
      fill_r    <= {LEN_W{1'b0}};
      pattern_r <= {PAT_W{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      overlap_r <= 1'b0;
      cfg_err_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      if (cfg_load) begin
        if (len_ok_s) begin
          state_r   <= ST_RUN;
          pattern_r <= cfg_pattern;
          len_r     <= cfg_len;
          overlap_r <= cfg_overlap;
          history_r <= {PAT_W{1'b0}};
          fill_r    <= {LEN_W{1'b0}};
          cfg_err_r <= 1'b0;
          busy_r    <= 1'b1;
        end else begin
          state_r   <= ST_IDLE;
          cfg_err_r <= 1'b1;
          busy_r    <= 1'b0;
        end
      end else begin
        case (state_r)
          ST_RUN: begin
            if (x_valid) begin
              history_r <= nh_s;
              if (match_s && !overlap_r) begin
                fill_r <= {LEN_W{1'b0}};
              end else if (fill_r < LEN_W'(PAT_W)) begin
                fill_r <= fill_inc_s[LEN_W-1:0];
              end else begin
                fill_r <= fill_r;
              end
            end else begin
              history_r <= history_r;
            end
          end
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating match counter.
  // A clear wins over an increment, but a match in the clear cycle counts as 1.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      cnt_r <= match_s ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
    end else if (match_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

`ifdef SEQDET_MEALY_EN
  assign z = match_s & aresetn;
`else
  logic z_r;

  // Registered match pulse, one cycle after the completing bit.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      z_r <= 1'b0;
    end else begin
      z_r <= match_s;
    end
  end

  assign z = z_r;
`endif

  assign match_cnt = cnt_r;
  assign cfg_err   = cfg_err_r;
  assign busy      = busy_r;

endmodule
